// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: decoder-side handshake and HI/LO result bus of the mul/div unit
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [5:0]       func;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mf_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic             stall;
  modport master (output start, func, rs_val, rt_val, mf_req,
                  input  hi, lo, busy, done, div_zero, stall);
  modport slave  (input  start, func, rs_val, rt_val, mf_req,
                  output hi, lo, busy, done, div_zero, stall);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: bit-serial MULT/MULTU/DIV/DIVU unit owning HI/LO, with MFHI/MFLO stall
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst,
  muldiv_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   a_q, b_q, rs_q, hi_q, lo_q;
  logic               is_div_q, neg_a_q, neg_b_q, busy_q, done_q, dz_q;
  logic               valid, sgn, dge, dzero;
  logic [WIDTH-1:0]   a_mag, b_mag, rdiff, quo, rem, fix_hi, fix_lo;
  logic [WIDTH:0]     msum, rsh;
  logic [2*WIDTH-1:0] mul_nx, div_nx, pfix;
  // Operand prep, one shift-add / restoring step, and the final sign fix-up
  always_comb begin
    valid  = bus.func[5:2] == 4'b0110;
    sgn    = ~bus.func[0];
    a_mag  = (sgn & bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    b_mag  = (sgn & bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
    msum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? a_q : {WIDTH{1'b0}})};
    mul_nx = {msum, prod_q[WIDTH-1:1]};
    rsh    = prod_q[2*WIDTH-1:WIDTH-1];
    dge    = rsh >= {1'b0, b_q};
    rdiff  = rsh[WIDTH-1:0] - b_q;
    div_nx = dge ? {rdiff, prod_q[WIDTH-2:0], 1'b1} : {rsh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    pfix   = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
    quo    = prod_q[WIDTH-1:0];
    rem    = prod_q[2*WIDTH-1:WIDTH];
    dzero  = is_div_q & (b_q == '0);
    fix_hi = !is_div_q ? pfix[2*WIDTH-1:WIDTH] : dzero ? rs_q : neg_a_q ? -rem : rem;
    fix_lo = !is_div_q ? pfix[WIDTH-1:0] : dzero ? {WIDTH{1'b1}} : (neg_a_q ^ neg_b_q) ? -quo : quo;
  end
  // Control FSM with registered HI/LO, busy and the done/div_zero pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rs_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        IDLE: if (bus.start && valid) begin
          state_q  <= ITER;
          cnt_q    <= '0;
          busy_q   <= 1'b1;
          is_div_q <= bus.func[1];
          neg_a_q  <= sgn & bus.rs_val[WIDTH-1];
          neg_b_q  <= sgn & bus.rt_val[WIDTH-1];
          a_q      <= a_mag;
          b_q      <= b_mag;
          rs_q     <= bus.rs_val;
          prod_q   <= {{WIDTH{1'b0}}, (bus.func[1] ? a_mag : b_mag)};
        end
        ITER: begin
          prod_q  <= is_div_q ? div_nx : mul_nx;
          cnt_q   <= (cnt_q == CNT_W'(WIDTH-1)) ? '0 : cnt_q + 1'b1;
          state_q <= (cnt_q == CNT_W'(WIDTH-1)) ? FIX : ITER;
        end
        FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          dz_q    <= dzero;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.stall    = bus.mf_req & busy_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: table-driven and directed checks of the mul/div sequencer
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  muldiv_sequencer_if #(.WIDTH(32)) bus ();
  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;
  typedef struct {
    logic [5:0]  f;
    logic [31:0] rs, rt, hi, lo;
    logic        dz;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.func = f; bus.rs_val = a; bus.rt_val = b;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic run_op(input string name, input vec_t v);
    int cyc;
    launch(v.f, v.rs, v.rt);
    cyc = 1;
    chk({name, " busy@1"}, 32'(bus.busy), 32'd1);
    while (!bus.done && cyc < 100) begin
      tick();
      cyc++;
    end
    chk({name, " latency"}, cyc, 34);
    chk({name, " hi"}, bus.hi, v.hi);
    chk({name, " lo"}, bus.lo, v.lo);
    chk({name, " div_zero"}, 32'(bus.div_zero), 32'(v.dz));
    chk({name, " busy@done"}, 32'(bus.busy), 32'd0);
    tick();
    chk({name, " done pulse width"}, 32'(bus.done | bus.div_zero), 32'd0);
  endtask
  initial begin
    int ndone;
    logic exp_stall;
    tbl[0] = '{F_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tbl[1] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[2] = '{F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[3] = '{F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    tbl[4] = '{F_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
    tbl[5] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
    tbl[6] = '{F_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'd0,        32'd30,       1'b0};
    tbl[7] = '{F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    tbl[8] = '{F_DIV,   32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1};
    tbl[9] = '{F_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0};
    bus.start = 1'b0; bus.func = '0; bus.rs_val = '0; bus.rt_val = '0; bus.mf_req = 1'b0;
    #2;
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    chk("reset busy/done/dz", {29'd0, bus.busy, bus.done, bus.div_zero}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), tbl[i]);
    bus.start = 1'b1; bus.func = 6'b100000; bus.rs_val = 32'd5; bus.rt_val = 32'd6;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bad func busy", 32'(bus.busy | bus.done), 32'd0);
      tick();
    end
    chk("bad func hi", bus.hi, tbl[9].hi);
    chk("bad func lo", bus.lo, tbl[9].lo);
    launch(F_MULT, 32'd3, 32'd5);
    ndone = 0;
    for (int c = 1; c <= 45; c++) begin
      bus.mf_req = (c >= 5 && c <= 40);
      bus.start = (c == 10);
      bus.func = F_MULT; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
      #1;
      exp_stall = (c >= 5 && c <= 33);
      chk($sformatf("stall c%0d", c), 32'(bus.stall), 32'(exp_stall));
      if (bus.done) ndone++;
      if (c == 20) begin
        chk("busy hold hi", bus.hi, tbl[9].hi);
        chk("busy hold lo", bus.lo, tbl[9].lo);
      end
      if (c == 34) chk("window done@34", 32'(bus.done), 32'd1);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    bus.mf_req = 1'b0;
    chk("window done count", ndone, 1);
    chk("window hi", bus.hi, 32'd0);
    chk("window lo", bus.lo, 32'd15);
    launch(F_MULT, 32'd1234, 32'd5678);
    repeat (14) tick();
    rst = 1'b1;
    #1;
    chk("abort hi", bus.hi, 32'd0);
    chk("abort lo", bus.lo, 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done || bus.busy) ndone++;
      tick();
    end
    chk("abort no done", ndone, 0);
    run_op("post-reset mult", '{F_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
